pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline. It drives the Stall/Flush inputs of the PC, IF_ID, ID_EXE, EXE_MEM and MEM_WB registers.
- Resolves load-use hazards, instruction-bus and data-bus wait states, and exception flushes.
- Sequences the multi-cycle mul/div unit in EXE through an internal FSM and cycle counter.
- Purely control: no datapath values pass through it.

Parameters:
MUL_CYCLES, 2, cycles the mul/div unit needs for MULT/MULTU (1..2^CNT_W)
DIV_CYCLES, 32, cycles the mul/div unit needs for DIV/DIVU (1..2^CNT_W)
CNT_W, 6, width of the internal mul/div down-counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
ID_rs  in  5  rs index of instruction in ID
ID_rt  in  5  rt index of instruction in ID
ID_use_rs  in  1  ID instruction reads rs
ID_use_rt  in  1  ID instruction reads rt
EXE_wreg  in  1  EXE instruction writes RF
EXE_is_load  in  1  EXE instruction is a load
EXE_regdst  in  5  EXE destination register
EXE_md_op  in  2  00 none, 01 mul, 10 div, 11 reserved (treated as none)
ibus_busy  in  1  instruction fetch not complete this cycle
dbus_busy  in  1  MEM-stage data access not complete this cycle
exc_valid  in  1  exception committed in MEM this cycle
PC_Stall  out  1  hold PC
IF_ID_Stall, IF_ID_Flush  out  1 each  IF/ID register controls
ID_EXE_Stall, ID_EXE_Flush  out  1 each  ID/EXE register controls
EXE_MEM_Stall, EXE_MEM_Flush  out  1 each  EXE/MEM register controls
MEM_WB_Stall, MEM_WB_Flush  out  1 each  MEM/WB register controls
md_start  out  1  one-cycle start pulse to the mul/div unit
md_done  out  1  mul/div result valid in EXE this cycle

Behaviour:
- Clocking and reset: single clock, rst synchronous active-high. FSM resets to IDLE and the counter to 0. On reset all outputs are 0. md_start and md_done are registered-state-derived and are 0 during rst.
- Load-use hazard: lu = EXE_is_load & EXE_wreg & (EXE_regdst!=0) & ((ID_use_rs & ID_rs==EXE_regdst) | (ID_use_rt & ID_rt==EXE_regdst)).
- Mul/div stall: md_stall = (state==IDLE & EXE_md_op in {01,10}) | state==BUSY.
- Stall chain (combinational):
  - s_mem = dbus_busy
  - s_exe = s_mem | md_stall
  - s_id = s_exe | lu
  - s_if = s_id | ibus_busy
- Normal outputs (exc_valid=0):
  - PC_Stall = s_if
  - IF_ID_Stall = s_id; IF_ID_Flush = ibus_busy & ~s_id
  - ID_EXE_Stall = s_exe; ID_EXE_Flush = lu & ~s_exe
  - EXE_MEM_Stall = s_mem; EXE_MEM_Flush = md_stall & ~s_mem
  - MEM_WB_Stall = 0; MEM_WB_Flush = s_mem
- Invariant: a register never has Stall and Flush both 1.
- Exception (exc_valid=1) overrides everything in the same cycle:
  - All five Flush outputs = 1, all Stall outputs = 0, PC_Stall = 0 (PC loads the vector).
  - md_start = 0; FSM goes to IDLE next cycle; counter cleared.
- Mul/div FSM:
  - IDLE: if EXE_md_op valid and ~exc_valid: md_start=1, counter <= (mul ? MUL_CYCLES : DIV_CYCLES)-1, go to BUSY.
  - BUSY: if counter==0 go to DONE, else decrement.
  - DONE: md_done=1, md_stall=0. Go to IDLE when ~s_mem; stay in DONE while s_mem.
- Latency: an op stalls EXE for exactly N+1 cycles (1 IDLE + N BUSY) and leaves EXE in the DONE cycle. N = MUL_CYCLES or DIV_CYCLES.
- md_start is asserted only in IDLE, so it never repeats while the same instruction is held by dbus_busy. A held instruction sits in DONE and does not restart.
- Counter wrap: none. It stops at 0. Parameters exceeding 2^CNT_W are illegal.
- Simultaneous events:
  - lu with dbus_busy: stalls dominate, no ID_EXE bubble.
  - ibus_busy with lu: PC and IF_ID held, IF_ID_Flush=0.
  - exc_valid during BUSY: operation aborted.
  - rst during BUSY: returns to IDLE with no md_done.

Test Plan:
- Load-use: EXE_is_load=1, EXE_wreg=1, EXE_regdst=5, ID_use_rs=1, ID_rs=5 → PC_Stall=1, IF_ID_Stall=1, ID_EXE_Flush=1, others 0. Same with EXE_regdst=0 → all 0.
- Div sequencing: EXE_md_op=10 with DIV_CYCLES=32 → md_start pulse at cycle 0, ID_EXE_Stall=1 and EXE_MEM_Flush=1 for 33 cycles, md_done=1 at cycle 33 with all stalls 0.
- Mul held by memory: mul with MUL_CYCLES=2, dbus_busy=1 during cycles 3-5 → md_done=1 on cycles 3-6, md_start pulses exactly once, EXE_MEM_Stall=1 and MEM_WB_Flush=1 on cycles 3-5.
- Exception abort: exc_valid=1 at cycle 10 of a div → all Flush=1, all Stall=0 that cycle; FSM back in IDLE; no md_done.
- Fetch wait: ibus_busy=1 alone for 3 cycles → PC_Stall=1 and IF_ID_Flush=1 for 3 cycles, ID_EXE/EXE_MEM/MEM_WB controls 0.
- Reset mid-operation: rst=1 during BUSY → next cycle all outputs 0, a new mul op afterwards gives md_start on its first EXE cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// It resolves load-use, bus wait and exception hazards and sequences the multi-cycle mul/div unit.
module pipeline_hazard_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_use_rs,
  input  logic       ID_use_rt,
  input  logic       EXE_wreg,
  input  logic       EXE_is_load,
  input  logic [4:0] EXE_regdst,
  input  logic [1:0] EXE_md_op,
  input  logic       ibus_busy,
  input  logic       dbus_busy,
  input  logic       exc_valid,
  output logic       PC_Stall,
  output logic       IF_ID_Stall,
  output logic       IF_ID_Flush,
  output logic       ID_EXE_Stall,
  output logic       ID_EXE_Flush,
  output logic       EXE_MEM_Stall,
  output logic       EXE_MEM_Flush,
  output logic       MEM_WB_Stall,
  output logic       MEM_WB_Flush,
  output logic       md_start,
  output logic       md_done
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic md_valid, lu, md_stall;
  logic s_mem, s_exe, s_id, s_if;

  always_comb begin
    md_valid = (EXE_md_op == 2'b01) || (EXE_md_op == 2'b10);
    lu = EXE_is_load && EXE_wreg && (EXE_regdst != 5'd0) &&
         ((ID_use_rs && (ID_rs == EXE_regdst)) || (ID_use_rt && (ID_rt == EXE_regdst)));
    md_stall = ((state_q == IDLE) && md_valid) || (state_q == BUSY);
    s_mem = dbus_busy;
    s_exe = s_mem || md_stall;
    s_id  = s_exe || lu;
    s_if  = s_id || ibus_busy;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (md_valid) begin
          state_d = BUSY;
          cnt_d   = (EXE_md_op == 2'b01) ? MUL_LOAD : DIV_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE: begin
        // The finished op stays parked here while MEM holds the pipe, so it never restarts.
        if (!s_mem) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (exc_valid) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    PC_Stall      = 1'b0;
    IF_ID_Stall   = 1'b0;
    IF_ID_Flush   = 1'b0;
    ID_EXE_Stall  = 1'b0;
    ID_EXE_Flush  = 1'b0;
    EXE_MEM_Stall = 1'b0;
    EXE_MEM_Flush = 1'b0;
    MEM_WB_Stall  = 1'b0;
    MEM_WB_Flush  = 1'b0;
    md_start      = 1'b0;
    md_done       = 1'b0;
    if (!rst) begin
      md_done = (state_q == DONE);
      if (exc_valid) begin
        IF_ID_Flush   = 1'b1;
        ID_EXE_Flush  = 1'b1;
        EXE_MEM_Flush = 1'b1;
        MEM_WB_Flush  = 1'b1;
      end else begin
        PC_Stall      = s_if;
        IF_ID_Stall   = s_id;
        IF_ID_Flush   = ibus_busy && !s_id;
        ID_EXE_Stall  = s_exe;
        ID_EXE_Flush  = lu && !s_exe;
        EXE_MEM_Stall = s_mem;
        EXE_MEM_Flush = md_stall && !s_mem;
        MEM_WB_Flush  = s_mem;
        md_start      = (state_q == IDLE) && md_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: table vectors, directed multi-cycle sequences, then random traffic vs. a model.
module tb_pipeline_hazard_ctrl;
  localparam int MUL_N = 2;
  localparam int DIV_N = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] ID_rs, ID_rt, EXE_regdst;
  logic       ID_use_rs, ID_use_rt, EXE_wreg, EXE_is_load;
  logic [1:0] EXE_md_op;
  logic       ibus_busy, dbus_busy, exc_valid;
  logic PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EXE_Stall, ID_EXE_Flush;
  logic EXE_MEM_Stall, EXE_MEM_Flush, MEM_WB_Stall, MEM_WB_Flush, md_start, md_done;

  pipeline_hazard_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_use_rs(ID_use_rs),
    .ID_use_rt(ID_use_rt), .EXE_wreg(EXE_wreg), .EXE_is_load(EXE_is_load),
    .EXE_regdst(EXE_regdst), .EXE_md_op(EXE_md_op), .ibus_busy(ibus_busy),
    .dbus_busy(dbus_busy), .exc_valid(exc_valid), .PC_Stall(PC_Stall),
    .IF_ID_Stall(IF_ID_Stall), .IF_ID_Flush(IF_ID_Flush), .ID_EXE_Stall(ID_EXE_Stall),
    .ID_EXE_Flush(ID_EXE_Flush), .EXE_MEM_Stall(EXE_MEM_Stall), .EXE_MEM_Flush(EXE_MEM_Flush),
    .MEM_WB_Stall(MEM_WB_Stall), .MEM_WB_Flush(MEM_WB_Flush), .md_start(md_start), .md_done(md_done)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       wreg;
    logic       is_load;
    logic [4:0] regdst;
    logic [1:0] md_op;
    logic       ibus;
    logic       dbus;
    logic       exc;
  } stim_t;

  // Output vector order: PC_S, IFID_S, IFID_F, IDEXE_S, IDEXE_F, EXMEM_S, EXMEM_F, MEMWB_S, MEMWB_F, start, done
  typedef struct {
    stim_t       stim;
    logic [10:0] exp;
    string       name;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model: remaining mul/div stall cycles after the current one, and a finished-op flag.
  int md_left = 0;
  bit md_fin  = 1'b0;

  function automatic stim_t blank();
    stim_t v;
    v = '0;
    return v;
  endfunction

  function automatic logic [10:0] ref_out(input stim_t v);
    logic lu, valid, stall_md, sm, se, si, sf, idle;
    if (v.rst) return 11'b0;
    valid    = (v.md_op == 2'd1) || (v.md_op == 2'd2);
    idle     = (md_left == 0) && !md_fin;
    stall_md = (md_left > 0) || (idle && valid);
    lu = v.is_load && v.wreg && (v.regdst != 0) &&
         ((v.use_rs && v.rs == v.regdst) || (v.use_rt && v.rt == v.regdst));
    if (v.exc) return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, md_fin};
    sm = v.dbus;
    se = sm || stall_md;
    si = se || lu;
    sf = si || v.ibus;
    return {sf, si, v.ibus && !si, se, lu && !se, sm, stall_md && !sm, 1'b0, sm,
            idle && valid, md_fin};
  endfunction

  task automatic model_step(input stim_t v);
    if (v.rst || v.exc) begin
      md_left = 0;
      md_fin  = 1'b0;
    end else if (md_fin) begin
      if (!v.dbus) md_fin = 1'b0;
    end else if (md_left > 0) begin
      md_left = md_left - 1;
      if (md_left == 0) md_fin = 1'b1;
    end else if (v.md_op == 2'd1) begin
      md_left = MUL_N;
    end else if (v.md_op == 2'd2) begin
      md_left = DIV_N;
    end
  endtask

  // Applies one cycle of stimulus, checks against the model and, when given, an explicit vector.
  task automatic cyc(input stim_t v, input logic [10:0] exp, input bit use_exp,
                     input string name, input bit verbose);
    logic [10:0] got, mdl;
    rst = v.rst; ID_rs = v.rs; ID_rt = v.rt; ID_use_rs = v.use_rs; ID_use_rt = v.use_rt;
    EXE_wreg = v.wreg; EXE_is_load = v.is_load; EXE_regdst = v.regdst; EXE_md_op = v.md_op;
    ibus_busy = v.ibus; dbus_busy = v.dbus; exc_valid = v.exc;
    #2;
    got = {PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EXE_Stall, ID_EXE_Flush, EXE_MEM_Stall,
           EXE_MEM_Flush, MEM_WB_Stall, MEM_WB_Flush, md_start, md_done};
    mdl = ref_out(v);
    checks++;
    if (got !== mdl) begin
      errors++;
      $display("FAIL %s model: got=%b expected=%b", name, got, mdl);
    end
    if (use_exp) begin
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got=%b expected=%b", name, got, exp);
      end
    end
    if (verbose) $display("%-14s in=%h out=%b", name, v, got);
    model_step(v);
    @(posedge clk);
    #1;
  endtask

  localparam logic [10:0] O_ZERO  = 11'b00000000000;
  localparam logic [10:0] O_LU    = 11'b11001000000;
  localparam logic [10:0] O_DBUS  = 11'b11010100100;
  localparam logic [10:0] O_IBUS  = 11'b10100000000;
  localparam logic [10:0] O_EXC   = 11'b00101010100;
  localparam logic [10:0] O_START = 11'b11010010010;
  localparam logic [10:0] O_BUSY  = 11'b11010010000;
  localparam logic [10:0] O_DONE  = 11'b00000000001;
  localparam logic [10:0] O_HELD  = 11'b11010100101;

  vec_t  tbl[12];
  stim_t s;

  initial begin
    // Table of single-cycle hazard cases, all with the mul/div unit idle.
    for (int i = 0; i < 12; i++) begin
      tbl[i].stim = blank();
      tbl[i].stim.is_load = 1'b1; tbl[i].stim.wreg = 1'b1;
      tbl[i].stim.regdst = 5'd5; tbl[i].stim.use_rs = 1'b1; tbl[i].stim.rs = 5'd5;
      tbl[i].exp = O_LU;
    end
    tbl[0].name = "lu_rs";
    tbl[1].name = "lu_r0";       tbl[1].stim.regdst = 5'd0; tbl[1].stim.rs = 5'd0; tbl[1].exp = O_ZERO;
    tbl[2].name = "lu_rt";       tbl[2].stim.use_rs = 1'b0; tbl[2].stim.use_rt = 1'b1;
                                 tbl[2].stim.rt = 5'd5;
    tbl[3].name = "rt_unused";   tbl[3].stim.use_rs = 1'b0; tbl[3].stim.rt = 5'd5; tbl[3].exp = O_ZERO;
    tbl[4].name = "not_load";    tbl[4].stim.is_load = 1'b0; tbl[4].exp = O_ZERO;
    tbl[5].name = "lu_dbus";     tbl[5].stim.dbus = 1'b1; tbl[5].exp = O_DBUS;
    tbl[6].name = "lu_ibus";     tbl[6].stim.ibus = 1'b1;
    tbl[7].name = "ibus_only";   tbl[7].stim = blank(); tbl[7].stim.ibus = 1'b1; tbl[7].exp = O_IBUS;
    tbl[8].name = "dbus_only";   tbl[8].stim = blank(); tbl[8].stim.dbus = 1'b1; tbl[8].exp = O_DBUS;
    tbl[9].name = "exc_lu";      tbl[9].stim.exc = 1'b1; tbl[9].exp = O_EXC;
    tbl[10].name = "quiet";      tbl[10].stim = blank(); tbl[10].exp = O_ZERO;
    tbl[11].name = "no_wreg";    tbl[11].stim.wreg = 1'b0; tbl[11].exp = O_ZERO;

    @(posedge clk); #1;
    s = blank(); s.rst = 1'b1; s.md_op = 2'd2; s.dbus = 1'b1; s.exc = 1'b1;
    for (int i = 0; i < 3; i++) cyc(s, O_ZERO, 1'b1, "reset", 1'b1);

    foreach (tbl[i]) cyc(tbl[i].stim, tbl[i].exp, 1'b1, tbl[i].name, 1'b1);

    // Divide: start pulse, DIV_N+1 stalled cycles, then done with no stalls.
    s = blank(); s.md_op = 2'd2;
    cyc(s, O_START, 1'b1, "div_c0", 1'b1);
    for (int i = 1; i <= DIV_N; i++) cyc(s, O_BUSY, 1'b1, "div_busy", 1'b1);
    cyc(s, O_DONE, 1'b1, "div_done", 1'b1);
    s = blank(); cyc(s, O_ZERO, 1'b1, "div_after", 1'b1);

    // Multiply held in DONE by a data-bus wait on cycles 3-5.
    s = blank(); s.md_op = 2'd1;
    cyc(s, O_START, 1'b1, "mul_c0", 1'b1);
    cyc(s, O_BUSY, 1'b1, "mul_c1", 1'b1);
    cyc(s, O_BUSY, 1'b1, "mul_c2", 1'b1);
    s.dbus = 1'b1;
    for (int i = 3; i <= 5; i++) cyc(s, O_HELD, 1'b1, "mul_held", 1'b1);
    s.dbus = 1'b0; cyc(s, O_DONE, 1'b1, "mul_c6", 1'b1);
    s = blank(); cyc(s, O_ZERO, 1'b1, "mul_after", 1'b1);

    // Exception at cycle 10 of a divide aborts it; a following mul starts from IDLE.
    s = blank(); s.md_op = 2'd2;
    cyc(s, O_START, 1'b1, "exc_div_c0", 1'b1);
    for (int i = 1; i < 10; i++) cyc(s, O_BUSY, 1'b1, "exc_div_busy", 1'b1);
    s.exc = 1'b1; cyc(s, O_EXC, 1'b1, "exc_abort", 1'b1);
    s = blank(); cyc(s, O_ZERO, 1'b1, "exc_idle", 1'b1);
    s.md_op = 2'd1; cyc(s, O_START, 1'b1, "exc_mul_c0", 1'b1);
    cyc(s, O_BUSY, 1'b1, "exc_mul_c1", 1'b1);
    cyc(s, O_BUSY, 1'b1, "exc_mul_c2", 1'b1);
    cyc(s, O_DONE, 1'b1, "exc_mul_done", 1'b1);
    s = blank(); cyc(s, O_ZERO, 1'b1, "exc_after", 1'b1);

    // Instruction fetch wait alone.
    s = blank(); s.ibus = 1'b1;
    for (int i = 0; i < 3; i++) cyc(s, O_IBUS, 1'b1, "fetch_wait", 1'b1);

    // Reset in the middle of a divide.
    s = blank(); s.md_op = 2'd2;
    cyc(s, O_START, 1'b1, "rst_div_c0", 1'b1);
    cyc(s, O_BUSY, 1'b1, "rst_div_c1", 1'b1);
    s.rst = 1'b1; cyc(s, O_ZERO, 1'b1, "rst_mid", 1'b1);
    s = blank(); cyc(s, O_ZERO, 1'b1, "rst_next", 1'b1);
    s.md_op = 2'd1; cyc(s, O_START, 1'b1, "rst_mul_c0", 1'b1);
    cyc(s, O_BUSY, 1'b1, "rst_mul_c1", 1'b1);
    cyc(s, O_BUSY, 1'b1, "rst_mul_c2", 1'b1);
    cyc(s, O_DONE, 1'b1, "rst_mul_done", 1'b1);

    // Random traffic against the reference model.
    for (int n = 0; n < 4000; n++) begin
      s = blank();
      s.rst     = ($urandom_range(0, 299) == 0);
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.use_rs  = 1'($urandom_range(0, 1));
      s.use_rt  = 1'($urandom_range(0, 1));
      s.wreg    = 1'($urandom_range(0, 1));
      s.is_load = 1'($urandom_range(0, 1));
      s.regdst  = 5'($urandom_range(0, 3));
      s.md_op   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      s.ibus    = ($urandom_range(0, 4) == 0);
      s.dbus    = ($urandom_range(0, 5) == 0);
      s.exc     = ($urandom_range(0, 59) == 0);
      cyc(s, O_ZERO, 1'b0, "random", 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
